// File: rtl/aftab_daru.sv
// aftab_daru: load-side byte assembler; reads 1-4 bytes little-endian from a byte-wide memory
module aftab_daru #(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           startDARU,
  input  logic           checkMisalignedDARU,
  input  logic [1:0]     nBytes,
  input  logic [len-1:0] addrIn,
  input  logic           memReady,
  input  logic [7:0]     dataIn,
  output logic [len-1:0] addrOut,
  output logic           readMem,
  output logic [len-1:0] dataOut,
  output logic           loadMisalignedFlag,
  output logic           completeDARU
);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  state_t           state;
  logic [len-1:0]   addr_reg;
  logic [1:0]       n_reg, cnt;
  logic             mis;
  assign mis = checkMisalignedDARU &&
               ((nBytes == 2'd1 && addrIn[0]) || (nBytes[1] && addrIn[1:0] != 2'b00));
  // readMem/addrOut are loaded with their next-state values; completeDARU follows DONE by one cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state              <= IDLE;
      addr_reg           <= '0;
      n_reg              <= '0;
      cnt                <= '0;
      addrOut            <= '0;
      readMem            <= 1'b0;
      dataOut            <= '0;
      loadMisalignedFlag <= 1'b0;
      completeDARU       <= 1'b0;
    end else begin
      loadMisalignedFlag <= 1'b0;
      completeDARU       <= 1'b0;
      case (state)
        IDLE: if (startDARU) begin
          addr_reg           <= addrIn;
          n_reg              <= nBytes;
          dataOut            <= '0;
          cnt                <= '0;
          loadMisalignedFlag <= mis;
          if (!mis) begin
            state   <= READ;
            readMem <= 1'b1;
            addrOut <= addrIn;
          end
        end
        READ: if (memReady) begin
          dataOut[8*cnt +: 8] <= dataIn;
          if (cnt == n_reg) begin
            state   <= DONE;
            readMem <= 1'b0;
            addrOut <= '0;
          end else begin
            cnt     <= cnt + 2'd1;
            addrOut <= addr_reg + len'(cnt + 2'd1);
          end
        end
        DONE: begin
          state        <= IDLE;
          completeDARU <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aftab_daru.sv
// tb_aftab_daru: directed and random load transactions checked against a byte-level reference model
module tb_aftab_daru;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startDARU = 1'b0;
  logic        checkMisalignedDARU = 1'b0;
  logic [1:0]  nBytes = '0;
  logic [31:0] addrIn = '0;
  logic        memReady = 1'b0;
  logic [7:0]  dataIn = '0;
  logic [31:0] addrOut;
  logic        readMem;
  logic [31:0] dataOut;
  logic        loadMisalignedFlag;
  logic        completeDARU;
  int          checks = 0;
  int          errors = 0;

  aftab_daru #(.len(32)) dut (
    .clk(clk), .rst(rst), .startDARU(startDARU), .checkMisalignedDARU(checkMisalignedDARU),
    .nBytes(nBytes), .addrIn(addrIn), .memReady(memReady), .dataIn(dataIn),
    .addrOut(addrOut), .readMem(readMem), .dataOut(dataOut),
    .loadMisalignedFlag(loadMisalignedFlag), .completeDARU(completeDARU)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, addrOut, 32'h0);
    chk({tag, "_rd"}, 32'(readMem), 32'h0);
    chk({tag, "_data"}, dataOut, 32'h0);
    chk({tag, "_mis"}, 32'(loadMisalignedFlag), 32'h0);
    chk({tag, "_cmp"}, 32'(completeDARU), 32'h0);
  endtask

  // gap: 0 = random memReady, 1 = always ready, g>1 = ready once every g cycles
  task automatic run(input logic [31:0] a, input logic [1:0] n, input logic chk_en, input int gap,
                     input bit use_pat, input logic [31:0] pat, input bit poke, input int abort);
    logic [31:0] exp;
    logic [7:0]  b;
    bit          misal, rdy;
    int          cyc, wait_n;
    misal = chk_en && ((n == 2'd1 && a[0]) || (n >= 2'd2 && a[1:0] != 2'b00));
    startDARU = 1'b1; checkMisalignedDARU = chk_en; nBytes = n; addrIn = a; memReady = 1'b0;
    step();
    cyc = 1;
    startDARU = 1'b0; addrIn = $urandom; nBytes = 2'($urandom);
    chk("mis_flag", 32'(loadMisalignedFlag), 32'(misal));
    chk("data_clr", dataOut, 32'h0);
    if (misal) begin
      chk("mis_rd", 32'(readMem), 32'h0);
      step();
      chk("mis_pulse", 32'(loadMisalignedFlag), 32'h0);
      chk("mis_rd2", 32'(readMem), 32'h0);
      chk("mis_cmp", 32'(completeDARU), 32'h0);
      return;
    end
    exp = '0;
    for (int k = 0; k <= int'(n); k++) begin
      if (k == abort) begin
        rst = 1'b0;
        #1;
        chk_zero("rst_now");
        step();
        step();
        chk_zero("rst_hold");
        rst = 1'b1;
        memReady = 1'b0;
        startDARU = 1'b0;
        return;
      end
      wait_n = 0;
      do begin
        chk("rd", 32'(readMem), 32'h1);
        chk("addr", addrOut, a + 32'(k));
        chk("part", dataOut, exp);
        chk("cmp_early", 32'(completeDARU), 32'h0);
        b = use_pat ? pat[8*k +: 8] : 8'($urandom);
        dataIn = b;
        memReady = (gap == 0) ? (wait_n >= 5 || $urandom_range(1) == 1) : (wait_n % gap == gap - 1);
        startDARU = poke;
        rdy = memReady;
        step();
        cyc++;
        wait_n++;
      end while (!rdy);
      exp[8*k +: 8] = b;
    end
    memReady = 1'b0; startDARU = 1'b0; dataIn = 8'($urandom);
    chk("done_rd", 32'(readMem), 32'h0);
    chk("done_addr", addrOut, 32'h0);
    chk("done_cmp", 32'(completeDARU), 32'h0);
    chk("done_data", dataOut, exp);
    step();
    cyc++;
    chk("cmp", 32'(completeDARU), 32'h1);
    chk("cmp_data", dataOut, exp);
    chk("cmp_rd", 32'(readMem), 32'h0);
    if (gap == 1) chk("latency", 32'(cyc), 32'(int'(n) + 3));
    step();
    chk("cmp_pulse", 32'(completeDARU), 32'h0);
    repeat (2) step();
    chk("held", dataOut, exp);
    chk("idle_rd", 32'(readMem), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    step();
    run(32'h0300FF54, 2'd3, 1'b1, 4, 1'b1, 32'hAA00FF0F, 1'b0, -1);
    run(32'h00000003, 2'd0, 1'b1, 1, 1'b1, 32'h00000080, 1'b0, -1);
    run(32'h00000101, 2'd1, 1'b1, 1, 1'b0, 32'h0, 1'b0, -1);
    run(32'h00000101, 2'd1, 1'b0, 1, 1'b0, 32'h0, 1'b0, -1);
    run(32'hFFFFFFFE, 2'd3, 1'b0, 1, 1'b0, 32'h0, 1'b0, -1);
    run($urandom, 2'd3, 1'b0, 0, 1'b0, 32'h0, 1'b1, -1);
    run(32'h00001000, 2'd3, 1'b1, 1, 1'b0, 32'h0, 1'b0, 2);
    run(32'h00002000, 2'd3, 1'b1, 1, 1'b0, 32'h0, 1'b0, -1);
    for (int i = 0; i < 30; i++)
      run($urandom, 2'($urandom), 1'($urandom), $urandom_range(2), 1'b0, 32'h0,
          1'($urandom), -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
